// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with combinational hit path and
// whole-line refill from a req/ack backing memory.
module icache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        hit,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned LSB_W = OFF_W + 2;
    localparam int unsigned TAG_W = 32 - IDX_W - LSB_W;
    localparam int unsigned LINE_W = 32 - LSB_W;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t              state;
    logic                abort;
    logic [OFF_W-1:0]    cnt;
    logic [LINE_W-1:0]   refill_line;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [31:0]         data_arr [LINES][WORDS];

    logic [OFF_W-1:0]    pc_off;
    logic [IDX_W-1:0]    pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic [IDX_W-1:0]    ref_idx;
    logic [TAG_W-1:0]    ref_tag;
    logic                last_word;
    logic                unused_ok;

    assign pc_off    = pc_f[LSB_W-1:2];
    assign pc_idx    = pc_f[LSB_W+IDX_W-1:LSB_W];
    assign pc_tag    = pc_f[31:LSB_W+IDX_W];
    assign ref_idx   = refill_line[IDX_W-1:0];
    assign ref_tag   = refill_line[LINE_W-1:IDX_W];
    assign last_word = (cnt == OFF_W'(WORDS - 1));
    assign unused_ok = ^pc_f[1:0];

    // Lookup path: only answers while the FSM is idle.
    always_comb begin
        hit   = (state == IDLE) && valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
        instr = hit ? data_arr[pc_idx][pc_off] : 32'h0;
        stall = !hit || (state != IDLE);
    end

    // Control FSM, valid bits and memory request registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            abort       <= 1'b0;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            refill_line <= '0;
            valid       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (!hit) begin
                        state       <= REFILL;
                        refill_line <= pc_f[31:LSB_W];
                        cnt         <= '0;
                        mem_req     <= 1'b1;
                        mem_addr    <= {pc_f[31:LSB_W], LSB_W'(0)};
                    end
                end
                REFILL: begin
                    if (flush) begin
                        valid <= '0;
                        abort <= 1'b1;
                    end
                    if (mem_ack) begin
                        if (last_word) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                            abort   <= 1'b0;
                            cnt     <= '0;
                            // A flush on the final ack also kills this line.
                            if (!abort && !flush) begin
                                valid[ref_idx] <= 1'b1;
                            end
                        end else begin
                            cnt      <= cnt + OFF_W'(1);
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage; never reset, guarded by the valid bits.
    always_ff @(posedge clk) begin
        if (rst_n && (state == REFILL) && mem_ack) begin
            data_arr[ref_idx][cnt] <= mem_data;
            if (last_word) begin
                tag_arr[ref_idx] <= ref_tag;
            end
        end
    end

endmodule
